// File: rtl/cpu_pkg.sv
// Shared datapath package: data width, operand-select codes and the
// occupancy states of the 2-entry operand skid buffer.
package cpu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OPSEL_RF    = 2'd0,
    OPSEL_EXMEM = 2'd1,
    OPSEL_MEMWB = 2'd2,
    OPSEL_IMM   = 2'd3
  } opsel_e;

  // Occupancy is the state: the encoding equals the number of stored entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/operand_sel_pipe_if.sv
// Decode-to-execute operand bus: producer side (in_*) and consumer side (out_*)
// of the operand select pipe. The producer/consumer uses master, the block uses slave.
interface operand_sel_pipe_if
  import cpu_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_sel_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel_err, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel_err, out_valid
  );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer with fully registered outputs; head is entry 0.
//   state    | meaning
//   ST_EMPTY | no entry stored, head invalid
//   ST_ONE   | entry 0 holds the head
//   ST_FULL  | entry 0 is the head, entry 1 the tail; push blocked
module skid_buf2
  import cpu_pkg::*;
#(
  parameter int W = DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] push_data,
  input  logic         push_valid,
  output logic         push_ready,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  input  logic         head_ready
);

  buf_state_e state_q, state_d;
  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic         ready_q;
  logic         push;
  logic         pop;

  assign push = push_valid & ready_q;
  assign pop  = (state_q != ST_EMPTY) & head_ready;

  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          ent0_d  = push_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          ent0_d = push_data;
        end else if (push) begin
          ent1_d  = push_data;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // ready_q is low here, so only the pop can happen
        if (pop) begin
          ent0_d  = ent1_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

  assign push_ready = ready_q;
  assign head_data  = ent0_q;
  assign head_valid = (state_q != ST_EMPTY);

endmodule

// File: rtl/operand_sel_pipe.sv
// N-way ALU B-operand select feeding a 2-entry skid buffer; out-of-range
// selects are stored as a zero word with the error flag set.
module operand_sel_pipe
  import cpu_pkg::*;
#(
  parameter  int WIDTH  = DATA_W,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input logic               clk,
  input logic               rst,
  operand_sel_pipe_if.slave bus
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic [WIDTH:0]   head;

  // A power-of-two input count cannot produce an out-of-range select.
  generate
    if (NUM_IN == (1 << SEL_W)) begin : g_full_range
      assign sel_word = bus.in_data[int'(bus.in_sel) * WIDTH +: WIDTH];
      assign sel_err  = 1'b0;
    end else begin : g_range_chk
      always_comb begin
        sel_word = '0;
        sel_err  = 1'b0;
        if (int'(bus.in_sel) < NUM_IN) begin
          sel_word = bus.in_data[int'(bus.in_sel) * WIDTH +: WIDTH];
        end else begin
          sel_err = 1'b1;
        end
      end
    end
  endgenerate

  skid_buf2 #(
    .W (WIDTH + 1)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_data  ({sel_word, sel_err}),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .head_data  (head),
    .head_valid (bus.out_valid),
    .head_ready (bus.out_ready)
  );

  assign bus.out_data    = head[WIDTH:1];
  assign bus.out_sel_err = head[0];

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed and randomised checks of operand_sel_pipe in three configurations:
// 32x4 (main), 32x3 (illegal select), 8x5 (random traffic against a queue model).
module tb_operand_sel_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  operand_sel_pipe_if #(.WIDTH(32), .NUM_IN(4)) ba ();
  operand_sel_pipe_if #(.WIDTH(32), .NUM_IN(3)) bb ();
  operand_sel_pipe_if #(.WIDTH(8),  .NUM_IN(5)) bc ();

  operand_sel_pipe #(.WIDTH(32), .NUM_IN(4)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
  operand_sel_pipe #(.WIDTH(32), .NUM_IN(3)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));
  operand_sel_pipe #(.WIDTH(8),  .NUM_IN(5)) dut_c (.clk(clk), .rst(rst), .bus(bc.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_a(input logic [31:0] word);
    ba.in_valid = 1'b1;
    ba.in_sel   = 2'd0;
    ba.in_data  = {96'h0, word};
  endtask

  logic [8:0]  q[$];
  logic [39:0] rdata;
  logic [8:0]  ent;
  int          rsel;
  bit          rv, rr, rpush;

  initial begin
    ba.in_data = '0; ba.in_sel = '0; ba.in_valid = 1'b0; ba.out_ready = 1'b0;
    bb.in_data = '0; bb.in_sel = '0; bb.in_valid = 1'b0; bb.out_ready = 1'b0;
    bc.in_data = '0; bc.in_sel = '0; bc.in_valid = 1'b0; bc.out_ready = 1'b0;

    // reset held for two edges
    repeat (2) @(negedge clk);
    chk("rst_valid", ba.out_valid, 1'b0);
    chk("rst_data",  ba.out_data,  32'h0);
    chk("rst_err",   ba.out_sel_err, 1'b0);
    chk("rst_ready", ba.in_ready,  1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", ba.in_ready, 1'b1);
    chk("rel_valid", ba.out_valid, 1'b0);

    // select sweep, one push per cycle
    ba.in_data   = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    ba.out_ready = 1'b1;
    ba.in_valid  = 1'b1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] exp_w;
      case (s)
        0: exp_w = 32'hAAAA_AAAA;
        1: exp_w = 32'hBBBB_BBBB;
        2: exp_w = 32'hCCCC_CCCC;
        default: exp_w = 32'hDDDD_DDDD;
      endcase
      ba.in_sel = 2'(s);
      @(negedge clk);
      chk("sel_valid", ba.out_valid, 1'b1);
      chk("sel_data",  ba.out_data,  exp_w);
      chk("sel_err",   ba.out_sel_err, 1'b0);
    end
    ba.in_valid = 1'b0;
    @(negedge clk);
    chk("sel_drain", ba.out_valid, 1'b0);

    // backpressure
    ba.out_ready = 1'b0;
    push_a(32'h11);
    @(negedge clk);
    chk("bp_d1", ba.out_data, 32'h11);
    chk("bp_rdy1", ba.in_ready, 1'b1);
    push_a(32'h22);
    @(negedge clk);
    chk("bp_rdy2", ba.in_ready, 1'b0);
    chk("bp_d2", ba.out_data, 32'h11);
    push_a(32'h33);
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_d", ba.out_data, 32'h11);
      chk("bp_hold_v", ba.out_valid, 1'b1);
      chk("bp_hold_r", ba.in_ready, 1'b0);
    end
    ba.in_valid  = 1'b0;
    ba.out_ready = 1'b1;
    chk("bp_first", ba.out_data, 32'h11);
    @(negedge clk);
    chk("bp_second", ba.out_data, 32'h22);
    chk("bp_second_v", ba.out_valid, 1'b1);
    @(negedge clk);
    chk("bp_nodup", ba.out_valid, 1'b0);
    chk("bp_rdy_back", ba.in_ready, 1'b1);

    // streaming through ONE with simultaneous push/pop
    for (int i = 1; i <= 100; i++) begin
      push_a(32'(i));
      @(negedge clk);
      chk("strm_data", ba.out_data, 64'(i));
      chk("strm_valid", ba.out_valid, 1'b1);
      chk("strm_ready", ba.in_ready, 1'b1);
    end
    ba.in_valid = 1'b0;
    @(negedge clk);
    chk("strm_end", ba.out_valid, 1'b0);

    // illegal select on the 3-input instance
    bb.out_ready = 1'b1;
    bb.in_data   = {96{1'b1}};
    bb.in_valid  = 1'b1;
    bb.in_sel    = 2'd3;
    @(negedge clk);
    chk("ill_valid", bb.out_valid, 1'b1);
    chk("ill_data",  bb.out_data,  32'h0);
    chk("ill_err",   bb.out_sel_err, 1'b1);
    bb.in_sel = 2'd1;
    @(negedge clk);
    chk("leg_data", bb.out_data, 32'hFFFF_FFFF);
    chk("leg_err",  bb.out_sel_err, 1'b0);
    bb.in_valid = 1'b0;
    @(negedge clk);
    chk("ill_drain", bb.out_valid, 1'b0);

    // reset while FULL
    ba.out_ready = 1'b0;
    push_a(32'h55);
    @(negedge clk);
    push_a(32'h66);
    @(negedge clk);
    ba.in_valid = 1'b0;
    chk("full_ready", ba.in_ready, 1'b0);
    chk("full_valid", ba.out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", ba.out_valid, 1'b0);
    chk("mrst_data",  ba.out_data,  32'h0);
    chk("mrst_ready", ba.in_ready,  1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_rel_ready", ba.in_ready, 1'b1);
    chk("mrst_rel_valid", ba.out_valid, 1'b0);
    ba.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mrst_no_old", ba.out_valid, 1'b0);
    end

    // random traffic on the 8x5 instance against a queue model
    for (int c = 0; c < 10000; c++) begin
      chk("rnd_valid", bc.out_valid, q.size() > 0);
      chk("rnd_ready", bc.in_ready, q.size() < 2);
      if (q.size() > 0) chk("rnd_head", {bc.out_data, bc.out_sel_err}, q[0]);
      rv    = ($urandom_range(0, 3) != 0);
      rr    = ($urandom_range(0, 2) != 0);
      rsel  = $urandom_range(0, 7);
      rdata = {$urandom, 8'($urandom)};
      bc.in_valid  = rv;
      bc.out_ready = rr;
      if (rv) begin
        bc.in_sel  = 3'(rsel);
        bc.in_data = rdata;
      end else begin
        bc.in_sel  = 'x;
        bc.in_data = 'x;
      end
      rpush = rv && (q.size() < 2);
      if (q.size() > 0 && rr) void'(q.pop_front());
      if (rpush) begin
        ent = (rsel < 5) ? {rdata[rsel*8 +: 8], 1'b0} : 9'h001;
        q.push_back(ent);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
